// File: rtl/lcd_pix_pkg.sv
// Shared types and helpers for the LCD pixel unpacker: state encoding,
// bits-per-pixel codes and the pixels-per-word lookup.
package lcd_pix_pkg;

  typedef enum logic {S_EMPTY, S_HOLD} upk_state_t;

  localparam logic [2:0] BPP1  = 3'd0;
  localparam logic [2:0] BPP2  = 3'd1;
  localparam logic [2:0] BPP4  = 3'd2;
  localparam logic [2:0] BPP8  = 3'd3;
  localparam logic [2:0] BPP16 = 3'd4;

  // Codes 5..7 are reserved and behave as 16bpp.
  function automatic logic [2:0] bpp_norm_f(input logic [2:0] bpp_code);
    return (bpp_code > BPP16) ? BPP16 : bpp_code;
  endfunction

  function automatic logic [5:0] ppw_f(input logic [2:0] bpp_code);
    case (bpp_norm_f(bpp_code))
      BPP1:    return 6'd32;
      BPP2:    return 6'd16;
      BPP4:    return 6'd8;
      BPP8:    return 6'd4;
      default: return 6'd2;
    endcase
  endfunction

endpackage

// File: rtl/lcd_pix_extract.sv
// Combinational pixel slicer: picks pixel idx out of a 32-bit word for the
// given depth and pixel order, zero-extended to 16 bits.
module lcd_pix_extract
  import lcd_pix_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [4:0]  idx_i,
  input  logic [2:0]  bpp_i,
  input  logic        be_i,
  output logic [15:0] pix_o
);

  logic [2:0]  code;
  logic [6:0]  lo_bit;
  logic [6:0]  shamt;
  logic [31:0] shifted;
  logic [15:0] mask;

  always_comb begin
    code   = bpp_norm_f(bpp_i);
    lo_bit = {2'b00, idx_i} << code;
    // MSB-first order counts slots down from bit 31 instead of up from bit 0.
    shamt  = be_i ? (7'd32 - (lo_bit + (7'd1 << code))) : lo_bit;
    shifted = word_i >> shamt;
    case (code)
      BPP1:    mask = 16'h0001;
      BPP2:    mask = 16'h0003;
      BPP4:    mask = 16'h000F;
      BPP8:    mask = 16'h00FF;
      default: mask = 16'hFFFF;
    endcase
    pix_o = shifted[15:0] & mask;
  end

endmodule

// File: rtl/lcd_pixel_unpacker.sv
// Consumer end of the LCD DMA FIFO: holds one word, hands out one pixel per
// pix_req, refills without a bubble and resyncs on the frame pulse.
module lcd_pixel_unpacker
  import lcd_pix_pkg::*;
#(
  parameter int DW = 32,
  parameter int PW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fp_pulse,
  input  logic [DW-1:0] fifo_rdata,
  input  logic          fifo_empty,
  output logic          fifo_pull,
  input  logic          pix_req,
  input  logic [2:0]    bpp_sel,
  input  logic          be_sel,
  output logic [PW-1:0] pix_data,
  output logic          pix_valid,
  output logic          underflow
);

  upk_state_t    state_q, state_d;
  logic [DW-1:0] word_q, word_d;
  logic [4:0]    idx_q, idx_d;
  logic [2:0]    bpp_q, bpp_d;
  logic          be_q, be_d;
  logic [PW-1:0] pix_data_q, pix_data_d;
  logic          pix_valid_q, pix_valid_d;
  logic          underflow_q, underflow_d;

  logic [15:0]   pixel;
  logic          last;

  lcd_pix_extract u_extract (
    .word_i (word_q),
    .idx_i  (idx_q),
    .bpp_i  (bpp_q),
    .be_i   (be_q),
    .pix_o  (pixel)
  );

  assign last = ({1'b0, idx_q} == (ppw_f(bpp_q) - 6'd1));

  // The FIFO flushes on the frame pulse, so its head word must not be taken then.
  assign fifo_pull = !fp_pulse && !fifo_empty &&
                     ((state_q == S_EMPTY) || (pix_req && last));

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d     = state_q;
    word_d      = word_q;
    idx_d       = idx_q;
    bpp_d       = bpp_q;
    be_d        = be_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    underflow_d = underflow_q;

    if (fp_pulse) begin
      state_d     = S_EMPTY;
      idx_d       = '0;
      underflow_d = 1'b0;
      bpp_d       = bpp_norm_f(bpp_sel);
      be_d        = be_sel;
    end else begin
      if (pix_req) begin
        if (state_q == S_HOLD) begin
          pix_data_d  = PW'(pixel);
          pix_valid_d = 1'b1;
          if (!last)           idx_d   = idx_q + 5'd1;
          else if (fifo_empty) state_d = S_EMPTY;
        end else begin
          pix_data_d  = '0;
          underflow_d = 1'b1;
        end
      end
      if (fifo_pull) begin
        word_d  = fifo_rdata;
        idx_d   = '0;
        state_d = S_HOLD;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      word_q      <= '0;
      idx_q       <= '0;
      bpp_q       <= BPP16;
      be_q        <= 1'b0;
      pix_data_q  <= '0;
      pix_valid_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      bpp_q       <= bpp_d;
      be_q        <= be_d;
      pix_data_q  <= pix_data_d;
      pix_valid_q <= pix_valid_d;
      underflow_q <= underflow_d;
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_lcd_pixel_unpacker.sv
// Self-checking bench for lcd_pixel_unpacker: a queue-based FIFO model feeds
// words, and expected pixels come from arithmetic unpacking of those words.
module tb_lcd_pixel_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        fp_pulse;
  logic [31:0] fifo_rdata;
  logic        fifo_empty;
  logic        fifo_pull;
  logic        pix_req;
  logic [2:0]  bpp_sel;
  logic        be_sel;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        underflow;

  int checks = 0;
  int errors = 0;
  int pulls  = 0;

  logic [31:0] fifo_q[$];
  logic [31:0] stim_q[$];
  logic [15:0] exp_q[$];

  lcd_pixel_unpacker #(.DW(32), .PW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .fp_pulse   (fp_pulse),
    .fifo_rdata (fifo_rdata),
    .fifo_empty (fifo_empty),
    .fifo_pull  (fifo_pull),
    .pix_req    (pix_req),
    .bpp_sel    (bpp_sel),
    .be_sel     (be_sel),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int bits_of(input logic [2:0] code);
    return (code >= 3'd4) ? 16 : (1 << code);
  endfunction

  // Pixel i of word w: contiguous bpp-bit field counted from LSB or MSB end.
  function automatic logic [15:0] ref_pix(input logic [31:0] w, input int bits,
                                          input bit be, input int i);
    int sh;
    longint unsigned m;
    sh = be ? (32 - (i + 1) * bits) : (i * bits);
    m  = (64'd1 << bits) - 64'd1;
    return 16'((64'(w) >> sh) & m);
  endfunction

  task automatic fifo_drive();
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? 32'h0 : fifo_q[0];
  endtask

  task automatic fifo_push(input logic [31:0] w);
    fifo_q.push_back(w);
    fifo_drive();
  endtask

  // One clock: observe the pull decision before the edge, update the FIFO
  // model just after it, and return 1ns past the edge for output sampling.
  task automatic tick();
    logic pulled;
    logic flush;
    @(negedge clk);
    pulled = fifo_pull;
    flush  = fp_pulse;
    checks++;
    assert (!(pulled && fifo_empty)) else begin
      errors++;
      $error("FAIL pull_while_empty observed=1 expected=0");
    end
    @(posedge clk);
    #1;
    if (flush) fifo_q.delete();
    else if (pulled && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (pulled) pulls++;
    fifo_drive();
  endtask

  task automatic frame(input logic [2:0] code, input bit be);
    bpp_sel  = code;
    be_sel   = be;
    fp_pulse = 1'b1;
    tick();
    fp_pulse = 1'b0;
    chk("fp_valid", 32'(pix_valid), 32'h0);
    chk("fp_underflow", 32'(underflow), 32'h0);
  endtask

  // Feeds stim_q through the DUT at the given (already latched) depth/order
  // and checks every produced pixel against the arithmetic reference.
  task automatic run_stream(input string name, input logic [2:0] code, input bit be,
                            input bit rand_req);
    int bits;
    int p0;
    int npix;
    int got;
    int budget;
    logic req;
    bits = bits_of(code);
    exp_q.delete();
    foreach (stim_q[k]) begin
      for (int i = 0; i < 32 / bits; i++) exp_q.push_back(ref_pix(stim_q[k], bits, be, i));
      fifo_push(stim_q[k]);
    end
    npix = exp_q.size();
    p0 = pulls;
    got = 0;
    budget = 0;
    pix_req = 1'b0;
    tick();
    while (exp_q.size() > 0 && budget < 4000) begin
      req = rand_req ? 1'($urandom_range(0, 1)) : 1'b1;
      pix_req = req;
      tick();
      budget++;
      chk({name, "_valid"}, 32'(pix_valid), 32'(req));
      if (req) begin
        chk({name, "_pix"}, 32'(pix_data), 32'(exp_q.pop_front()));
        got++;
      end
    end
    if (exp_q.size() > 0) chk({name, "_budget"}, 32'(exp_q.size()), 32'h0);
    pix_req = 1'b0;
    tick();
    chk({name, "_idle_valid"}, 32'(pix_valid), 32'h0);
    chk({name, "_count"}, 32'(got), 32'(npix));
    chk({name, "_pulls"}, 32'(pulls - p0), 32'(stim_q.size()));
    chk({name, "_underflow"}, 32'(underflow), 32'h0);
  endtask

  initial begin
    int p0;
    rst = 1'b1;
    fp_pulse = 1'b0;
    pix_req = 1'b0;
    bpp_sel = 3'd0;
    be_sel = 1'b1;
    fifo_drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", 32'(pix_data), 32'h0);
    chk("rst_valid", 32'(pix_valid), 32'h0);
    chk("rst_underflow", 32'(underflow), 32'h0);
    chk("rst_pull", 32'(fifo_pull), 32'h0);
    rst = 1'b0;
    tick();

    // Reset depth is 16bpp LSB-first; the selects are ignored without a frame pulse.
    stim_q = '{32'hBBBBAAAA, 32'hDDDDCCCC};
    run_stream("b16", 3'd4, 1'b0, 1'b0);

    frame(3'd3, 1'b1);
    stim_q = '{32'h11223344};
    run_stream("b8_be", 3'd3, 1'b1, 1'b0);

    frame(3'd3, 1'b0);
    stim_q = '{32'h11223344};
    run_stream("b8_le", 3'd3, 1'b0, 1'b0);

    frame(3'd0, 1'b0);
    stim_q = '{32'h80000001};
    run_stream("b1", 3'd0, 1'b0, 1'b0);

    // Underflow: request with nothing held, sticky until the frame pulse.
    frame(3'd4, 1'b0);
    p0 = pulls;
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    chk("uf_valid", 32'(pix_valid), 32'h0);
    chk("uf_data", 32'(pix_data), 32'h0);
    chk("uf_flag", 32'(underflow), 32'h1);
    repeat (3) tick();
    chk("uf_sticky", 32'(underflow), 32'h1);
    chk("uf_pulls", 32'(pulls - p0), 32'h0);
    pix_req = 1'b1;
    fp_pulse = 1'b1;
    tick();
    fp_pulse = 1'b0;
    pix_req = 1'b0;
    chk("uf_fp_clear", 32'(underflow), 32'h0);
    chk("uf_fp_drop_valid", 32'(pix_valid), 32'h0);
    tick();
    chk("uf_fp_no_set", 32'(underflow), 32'h0);

    // A word that appears together with the frame pulse must not be pulled.
    fifo_push(32'h12345678);
    p0 = pulls;
    fp_pulse = 1'b1;
    tick();
    fp_pulse = 1'b0;
    chk("fp_no_pull", 32'(pulls - p0), 32'h0);

    // Resync mid-word at 4bpp; 8bpp selected mid-frame only applies after the pulse.
    frame(3'd2, 1'b0);
    fifo_push(32'h87654321);
    fifo_push(32'hFEDCBA98);
    tick();
    for (int i = 0; i < 3; i++) begin
      pix_req = 1'b1;
      if (i == 1) bpp_sel = 3'd3;
      tick();
      chk("rs_pix", 32'(pix_data), 32'(ref_pix(32'h87654321, 4, 1'b0, i)));
    end
    p0 = pulls;
    fp_pulse = 1'b1;
    tick();
    fp_pulse = 1'b0;
    pix_req = 1'b0;
    chk("rs_fp_valid", 32'(pix_valid), 32'h0);
    chk("rs_fp_underflow", 32'(underflow), 32'h0);
    chk("rs_fp_pulls", 32'(pulls - p0), 32'h0);
    stim_q = '{32'h11223344};
    run_stream("rs_b8", 3'd3, 1'b0, 1'b0);

    // Randomized frames with random request gaps.
    for (int r = 0; r < 8; r++) begin
      logic [2:0] code;
      bit be;
      int nw;
      code = 3'($urandom_range(0, 7));
      be = 1'($urandom_range(0, 1));
      nw = $urandom_range(1, 3);
      frame(code, be);
      stim_q.delete();
      for (int k = 0; k < nw; k++) stim_q.push_back($urandom);
      run_stream("rnd", code, be, 1'b1);
    end

    // Async reset mid-word: outputs clear before any further clock edge.
    frame(3'd3, 1'b0);
    pix_req = 1'b1;
    tick();
    chk("ar_pre_underflow", 32'(underflow), 32'h1);
    fifo_push(32'hA5C3E1F0);
    pix_req = 1'b0;
    tick();
    pix_req = 1'b1;
    tick();
    pix_req = 1'b0;
    chk("ar_pre_valid", 32'(pix_valid), 32'h1);
    chk("ar_pre_data", 32'(pix_data), 32'h00F0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(pix_valid), 32'h0);
    chk("ar_data", 32'(pix_data), 32'h0);
    chk("ar_underflow", 32'(underflow), 32'h0);
    #1;
    rst = 1'b0;
    fifo_q.delete();
    fifo_drive();
    tick();
    chk("ar_post_valid", 32'(pix_valid), 32'h0);
    // Back at reset depth (16bpp LSB-first) with the old word discarded.
    stim_q = '{32'h0F0E0D0C};
    run_stream("ar_b16", 3'd4, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
